// File: rtl/sc_ifu.sv
// sc_ifu: instruction fetch unit for the single-cycle MIPS core.
// Holds the PC, fetches one instruction per commit over a req/ack imem port,
// presents it to decode, and computes the next PC from pcsource/ra.
//
// Ports:
//   clock, resetn           clock (rising edge), async active-low reset
//   pcsource[1:0]           next-PC select: 00 pc+4, 01 branch, 10 jr, 11 j/jal
//   ra[31:0]                rs value for jr
//   commit                  current instruction finished; pcsource/ra valid
//   imem_req, imem_addr     fetch request (held until ack), fetch address (= pc)
//   imem_rdata, imem_ack    instruction word, one-cycle completion strobe
//   pc, pc4                 current instruction address, pc + 4 (combinational)
//   inst, inst_valid        fetched instruction and its valid flag
//   fetch_err               sticky ack-timeout flag
//   misalign                sticky misaligned-jr flag (trap build only)
//
// Build option: define IFU_MISALIGN_TRAP_EN to redirect misaligned jr targets
// to TRAP_PC and raise misalign; otherwise jr clears ra[1:0] and misalign is 0.
module sc_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_err,
  output logic        misalign
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_EXEC = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              req_q, req_d;
  logic              fetch_err_q, fetch_err_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  logic [XLEN-1:0]   pc4_c;
  logic [XLEN-1:0]   br_off_c;
  logic [XLEN-1:0]   npc_c;
  logic              trap_c;

  // Next-PC selection; all arithmetic wraps modulo 2^32.
  always_comb begin
    pc4_c    = pc_q + XLEN'(4);
    br_off_c = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    trap_c   = 1'b0;
    npc_c    = pc4_c;
    case (pcsource)
      2'b00: npc_c = pc4_c;
      2'b01: npc_c = pc4_c + br_off_c;
      2'b10: npc_c = {ra[31:2], 2'b00};
      2'b11: npc_c = {pc4_c[31:28], inst_q[25:0], 2'b00};
      default: npc_c = pc4_c;
    endcase
`ifdef IFU_MISALIGN_TRAP_EN
    if ((pcsource == 2'b10) && (ra[1:0] != 2'b00)) begin
      npc_c  = TRAP_PC;
      trap_c = 1'b1;
    end
`endif
  end

`ifndef IFU_MISALIGN_TRAP_EN
  // Trap target and low jr bits have no consumer in this build.
  logic unused_trap;
  assign unused_trap = ^{TRAP_PC, ra[1:0]};
`endif

  // Fetch FSM next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    req_d        = req_q;
    fetch_err_d  = fetch_err_q;
    misalign_d   = misalign_q;
    wait_d       = wait_q;

    case (state_q)
      S_REQ: begin
        req_d = 1'b1;
        // Only an ack to a request actually on the bus is accepted.
        if (req_q && imem_ack) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          wait_d       = '0;
          req_d        = 1'b0;
          state_d      = S_EXEC;
        end else if (req_q && (TIMEOUT != 0)) begin
          wait_d = wait_q + CNT_W'(1);
          if (wait_d == CNT_W'(TIMEOUT)) begin
            fetch_err_d = 1'b1;
            req_d       = 1'b0;
            state_d     = S_HALT;
          end
        end
      end
      S_EXEC: begin
        req_d = 1'b0;
        if (commit) begin
          pc_d         = npc_c;
          inst_valid_d = 1'b0;
          misalign_d   = misalign_q | trap_c;
          req_d        = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_HALT: begin
        req_d        = 1'b0;
        inst_valid_d = 1'b0;
      end
      default: begin
        req_d        = 1'b0;
        inst_valid_d = 1'b0;
        state_d      = S_HALT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b0;
      fetch_err_q  <= 1'b0;
      misalign_q   <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      req_q        <= req_d;
      fetch_err_q  <= fetch_err_d;
      misalign_q   <= misalign_d;
      wait_q       <= wait_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc4        = pc4_c;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign fetch_err  = fetch_err_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_sc_ifu.sv
// Directed self-checking bench for sc_ifu.
module tb_sc_ifu;

  logic        clk;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] ra;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_err;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_jr_pc;
  logic [31:0] exp_mis;

  sc_ifu #(
    .RESET_PC (32'h0000_0000),
    .TRAP_PC  (32'h0000_0080),
    .TIMEOUT  (16)
  ) dut (
    .clock      (clk),
    .resetn     (resetn),
    .pcsource   (pcsource),
    .ra         (ra),
    .commit     (commit),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .pc         (pc),
    .pc4        (pc4),
    .inst       (inst),
    .inst_valid (inst_valid),
    .fetch_err  (fetch_err),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ack the outstanding request lat cycles after it was raised.
  task automatic fetch(input logic [31:0] word, input int lat);
    repeat (lat - 1) tick();
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic do_commit(input logic [1:0] sel, input logic [31:0] rv);
    pcsource = sel;
    ra       = rv;
    commit   = 1'b1;
    tick();
    commit   = 1'b0;
    pcsource = 2'b00;
    ra       = 32'h0;
  endtask

  initial begin
    resetn     = 1'b0;
    pcsource   = 2'b00;
    ra         = 32'h0;
    commit     = 1'b0;
    imem_rdata = 32'h0;
    imem_ack   = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    exp_jr_pc = 32'h0000_0080;
    exp_mis   = 32'd1;
`else
    exp_jr_pc = 32'h0000_0200;
    exp_mis   = 32'd0;
`endif

    #12;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_pc",    pc, 32'h0);
    check("rst_inst",  inst, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_err",   32'(fetch_err), 32'd0);
    check("rst_mis",   32'(misalign), 32'd0);

    @(posedge clk); #1;
    resetn = 1'b1;
    tick();
    check("req_rise", 32'(imem_req), 32'd1);
    check("addr0",    imem_addr, 32'h0);

    // First fetch, ack two cycles after request.
    tick();
    check("valid_before_ack", 32'(inst_valid), 32'd0);
    fetch(32'h2001_0005, 1);
    check("inst0",   inst, 32'h2001_0005);
    check("valid0",  32'(inst_valid), 32'd1);
    check("req_low", 32'(imem_req), 32'd0);
    check("pc4_0",   pc4, 32'h4);
    do_commit(2'b00, 32'h0);
    check("addr_seq", imem_addr, 32'h4);
    check("req_seq",  32'(imem_req), 32'd1);
    check("valid_clr", 32'(inst_valid), 32'd0);

    // j to 0x100.
    fetch(32'h0800_0040, 1);
    do_commit(2'b11, 32'h0);
    check("j_pc", pc, 32'h100);

    // beq offset -2 with stray ack in EXEC and ack alongside commit.
    fetch(32'h1000_FFFE, 3);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    check("stray_ack_inst", inst, 32'h1000_FFFE);
    check("stray_ack_valid", 32'(inst_valid), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBEEF_0000;
    do_commit(2'b01, 32'h0);
    imem_ack   = 1'b0;
    check("beq_pc",   pc, 32'h0000_00FC);
    check("beq_inst", inst, 32'h1000_FFFE);
    check("beq_valid", 32'(inst_valid), 32'd0);

    // Commit while fetching is ignored.
    do_commit(2'b11, 32'h0);
    check("commit_in_req", pc, 32'h0000_00FC);

    // jr to 0x3000_0010, then jal.
    fetch(32'h0000_0000, 1);
    do_commit(2'b10, 32'h3000_0010);
    check("jr_pc", pc, 32'h3000_0010);
    fetch(32'h0C00_0040, 2);
    check("jal_pc4", pc4, 32'h3000_0014);
    do_commit(2'b11, 32'h0);
    check("jal_pc", pc, 32'h3000_0100);

    // Misaligned jr.
    fetch(32'h0060_0008, 1);
    do_commit(2'b10, 32'h0000_0203);
    check("mis_pc",  pc, exp_jr_pc);
    check("mis_flag", 32'(misalign), exp_mis);

    // Timeout: 16 request cycles with no ack.
    repeat (15) tick();
    check("to_err_15", 32'(fetch_err), 32'd0);
    check("to_req_15", 32'(imem_req), 32'd1);
    tick();
    check("to_err",   32'(fetch_err), 32'd1);
    check("to_req",   32'(imem_req), 32'd0);
    check("to_valid", 32'(inst_valid), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    do_commit(2'b00, 32'h0);
    imem_ack   = 1'b0;
    tick();
    check("halt_req",   32'(imem_req), 32'd0);
    check("halt_valid", 32'(inst_valid), 32'd0);
    check("halt_pc",    pc, exp_jr_pc);
    check("halt_err",   32'(fetch_err), 32'd1);

    // Reset mid-wait.
    resetn = 1'b0;
    #1;
    check("rst_halt_err", 32'(fetch_err), 32'd0);
    resetn = 1'b1;
    tick();
    tick();
    check("rerun_req", 32'(imem_req), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_pc",  pc, 32'h0);
    check("midrst_mis", 32'(misalign), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ack   = 1'b0;
    resetn     = 1'b1;
    check("midrst_inst", inst, 32'h0);
    tick();
    check("post_rst_req",   32'(imem_req), 32'd1);
    check("post_rst_valid", 32'(inst_valid), 32'd0);
    fetch(32'h2001_0005, 2);
    check("post_rst_inst", inst, 32'h2001_0005);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
